// File: rtl/i3_pkg.sv
// Shared definitions for the i3 operand loader: beat count, field widths,
// loader state encoding and the assembled 132-bit operand frame.
package i3_pkg;

  localparam int I3_BEATS  = 5;
  localparam int I3_IDX_W  = 3;
  localparam int I3_BEAT_W = 32;

  localparam int PV28_W  = 28;
  localparam int PV56_W  = 28;
  localparam int PV88_W  = 32;
  localparam int PV120_W = 32;
  localparam int PV126_W = 6;
  localparam int PV132_W = 6;

  localparam logic [I3_IDX_W-1:0] I3_LAST_IDX = I3_IDX_W'(I3_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FULL
  } i3_state_e;

  typedef struct packed {
    logic [PV28_W-1:0]  pv28;
    logic [PV56_W-1:0]  pv56;
    logic [PV88_W-1:0]  pv88;
    logic [PV120_W-1:0] pv120;
    logic [PV126_W-1:0] pv126;
    logic [PV132_W-1:0] pv132;
  } i3_frame_t;

  // Beats 0/1 carry 28 payload bits and beat 4 carries 12; everything above must be zero.
  function automatic logic beat_pad_bad(input logic [I3_IDX_W-1:0] idx,
                                        input logic [I3_BEAT_W-1:0] data);
    logic bad;
    bad = 1'b0;
    case (idx)
      3'd0, 3'd1: bad = |data[I3_BEAT_W-1:PV28_W];
      3'd4:       bad = |data[I3_BEAT_W-1:PV126_W+PV132_W];
      default:    bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/i3_beat_ctr.sv
// Beat index counter for the i3 operand loader: clear to 0, load to 1
// (a start-of-frame beat was just stored as beat 0) or increment.
module i3_beat_ctr
  import i3_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic                inc_i,
  input  logic                clear_i,
  output logic [I3_IDX_W-1:0] idx_o,
  output logic                last_o
);

  logic [I3_IDX_W-1:0] idx_q;
  logic [I3_IDX_W-1:0] idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (load_i) begin
      idx_d = I3_IDX_W'(1);
    end else if (inc_i) begin
      idx_d = idx_q + I3_IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == I3_LAST_IDX);

endmodule

// File: rtl/i3_operand_loader.sv
// Collects five 32-bit beats into one 132-bit operand frame for the i3 core,
// holds it until the consumer accepts it, and flags framing/padding errors.
module i3_operand_loader
  import i3_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int PAD_CHECK = 1
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sof,
  input  logic [I3_BEAT_W-1:0] in_data,
  output logic                 frm_valid,
  input  logic                 frm_ready,
  output logic [PV28_W-1:0]    pv28_o,
  output logic [PV56_W-1:0]    pv56_o,
  output logic [PV88_W-1:0]    pv88_o,
  output logic [PV120_W-1:0]   pv120_o,
  output logic [PV126_W-1:0]   pv126_o,
  output logic [PV132_W-1:0]   pv132_o,
  output logic                 frm_pad_err,
  output logic                 err_sync,
  output logic [CNT_W-1:0]     frm_cnt
);

  i3_state_e           state_q, state_d;
  i3_frame_t           frame_q, frame_d;
  logic                pad_acc_q, pad_acc_d;
  logic [CNT_W-1:0]    frm_cnt_q, frm_cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                frm_valid_q, frm_valid_d;
  logic                frm_pad_err_q, frm_pad_err_d;
  logic                err_sync_q, err_sync_d;

  logic                beat_xfer;
  logic                frm_xfer;
  logic                wr_en;
  logic [I3_IDX_W-1:0] wr_idx;
  logic                pad_bit;
  logic                ctr_load, ctr_inc, ctr_clear;
  logic [I3_IDX_W-1:0] beat_idx;
  logic                last_beat;

  assign beat_xfer = in_valid & in_ready_q;
  assign frm_xfer  = frm_valid_q & frm_ready;

  i3_beat_ctr u_beat_ctr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ctr_load),
    .inc_i   (ctr_inc),
    .clear_i (ctr_clear),
    .idx_o   (beat_idx),
    .last_o  (last_beat)
  );

  always_comb begin
    state_d    = state_q;
    frm_cnt_d  = frm_cnt_q;
    err_sync_d = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = beat_idx;
    ctr_load   = 1'b0;
    ctr_inc    = 1'b0;
    ctr_clear  = 1'b0;

    case (state_q)
      IDLE: begin
        if (beat_xfer) begin
          if (in_sof) begin
            wr_en    = 1'b1;
            wr_idx   = '0;
            ctr_load = 1'b1;
            state_d  = COLLECT;
          end else begin
            err_sync_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (beat_xfer) begin
          // A fresh start-of-frame abandons the partial frame and restarts on this beat.
          if (in_sof) begin
            err_sync_d = 1'b1;
            wr_en      = 1'b1;
            wr_idx     = '0;
            ctr_load   = 1'b1;
          end else begin
            wr_en = 1'b1;
            if (last_beat) begin
              ctr_clear = 1'b1;
              state_d   = FULL;
            end else begin
              ctr_inc = 1'b1;
            end
          end
        end
      end
      FULL: begin
        if (frm_xfer) begin
          frm_cnt_d = frm_cnt_q + CNT_W'(1);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    frame_d   = frame_q;
    pad_acc_d = pad_acc_q;
    pad_bit   = (PAD_CHECK != 0) && beat_pad_bad(wr_idx, in_data);
    if (wr_en) begin
      case (wr_idx)
        3'd0: begin
          frame_d.pv28 = in_data[PV28_W-1:0];
          pad_acc_d    = pad_bit;
        end
        3'd1: begin
          frame_d.pv56 = in_data[PV56_W-1:0];
          pad_acc_d    = pad_acc_q | pad_bit;
        end
        3'd2: frame_d.pv88  = in_data[PV88_W-1:0];
        3'd3: frame_d.pv120 = in_data[PV120_W-1:0];
        3'd4: begin
          frame_d.pv126 = in_data[PV126_W-1:0];
          frame_d.pv132 = in_data[PV126_W+PV132_W-1:PV126_W];
          pad_acc_d     = pad_acc_q | pad_bit;
        end
        default: frame_d = frame_q;
      endcase
    end

    // Handshake and status flops look one state ahead so every output is a plain register.
    in_ready_d    = (state_d != FULL);
    frm_valid_d   = (state_d == FULL);
    frm_pad_err_d = (state_d == FULL) & pad_acc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      frame_q       <= '0;
      pad_acc_q     <= 1'b0;
      frm_cnt_q     <= '0;
      in_ready_q    <= 1'b1;
      frm_valid_q   <= 1'b0;
      frm_pad_err_q <= 1'b0;
      err_sync_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_q       <= frame_d;
      pad_acc_q     <= pad_acc_d;
      frm_cnt_q     <= frm_cnt_d;
      in_ready_q    <= in_ready_d;
      frm_valid_q   <= frm_valid_d;
      frm_pad_err_q <= frm_pad_err_d;
      err_sync_q    <= err_sync_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign frm_valid   = frm_valid_q;
  assign frm_pad_err = frm_pad_err_q;
  assign err_sync    = err_sync_q;
  assign frm_cnt     = frm_cnt_q;
  assign pv28_o      = frame_q.pv28;
  assign pv56_o      = frame_q.pv56;
  assign pv88_o      = frame_q.pv88;
  assign pv120_o     = frame_q.pv120;
  assign pv126_o     = frame_q.pv126;
  assign pv132_o     = frame_q.pv132;

endmodule

// File: tb/tb_i3_operand_loader.sv
// Scoreboard bench for i3_operand_loader: a beat-level reference model queues
// expected frames, and a monitor pops and compares them at every handoff.
module tb_i3_operand_loader;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_sof;
  logic [31:0]      in_data;
  logic             frm_valid;
  logic             frm_ready;
  logic [27:0]      pv28_o;
  logic [27:0]      pv56_o;
  logic [31:0]      pv88_o;
  logic [31:0]      pv120_o;
  logic [5:0]       pv126_o;
  logic [5:0]       pv132_o;
  logic             frm_pad_err;
  logic             err_sync;
  logic [CNT_W-1:0] frm_cnt;

  int checks = 0;
  int errors = 0;

  logic [132:0]     expQ[$];
  logic [CNT_W-1:0] expCnt = '0;
  int               expErr = 0;
  int               errSeen = 0;
  logic [31:0]      mBeats[5];
  int               mIdx = 0;
  bit               mActive = 1'b0;

  i3_operand_loader #(.CNT_W(CNT_W), .PAD_CHECK(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sof      (in_sof),
    .in_data     (in_data),
    .frm_valid   (frm_valid),
    .frm_ready   (frm_ready),
    .pv28_o      (pv28_o),
    .pv56_o      (pv56_o),
    .pv88_o      (pv88_o),
    .pv120_o     (pv120_o),
    .pv126_o     (pv126_o),
    .pv132_o     (pv132_o),
    .frm_pad_err (frm_pad_err),
    .err_sync    (err_sync),
    .frm_cnt     (frm_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [132:0] observed,
                             input logic [132:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [132:0] modelFrame();
    logic pad;
    pad = (|mBeats[0][31:28]) | (|mBeats[1][31:28]) | (|mBeats[4][31:12]);
    return {mBeats[0][27:0], mBeats[1][27:0], mBeats[2], mBeats[3],
            mBeats[4][5:0], mBeats[4][11:6], pad};
  endfunction

  // Drives one beat, waits (bounded) for it to be accepted, then updates the model.
  task automatic applyStimulus(input logic [31:0] d, input logic sof);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checkOutput("beat_accept_timeout", {132'd0, in_ready}, 133'd1);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (sof) begin
      if (mActive) expErr++;
      mActive   = 1'b1;
      mBeats[0] = d;
      mIdx      = 1;
    end else if (!mActive) begin
      expErr++;
    end else begin
      mBeats[mIdx] = d;
      if (mIdx == 4) begin
        expQ.push_back(modelFrame());
        mActive = 1'b0;
        mIdx    = 0;
      end else begin
        mIdx++;
      end
    end
  endtask

  task automatic sendFrame(input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                           input logic [31:0] b3, input logic [31:0] b4);
    applyStimulus(b0, 1'b1);
    applyStimulus(b1, 1'b0);
    applyStimulus(b2, 1'b0);
    applyStimulus(b3, 1'b0);
    applyStimulus(b4, 1'b0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    expQ.delete();
    expCnt  = '0;
    mActive = 1'b0;
    mIdx    = 0;
  endtask

  task automatic stepCycle();
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (err_sync) errSeen++;
      if (frm_valid && frm_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious_frame", 133'd1, 133'd0);
        end else begin
          checkOutput("frame", {pv28_o, pv56_o, pv88_o, pv120_o, pv126_o, pv132_o, frm_pad_err},
                      expQ.pop_front());
        end
        expCnt = expCnt + 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] errBefore;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = '0;
    frm_ready = 1'b1;
    doReset();

    $display("[TB] reset values");
    checkOutput("rst_in_ready", {132'd0, in_ready}, 133'd1);
    checkOutput("rst_outputs", {frm_valid, frm_pad_err, err_sync, frm_cnt}, 133'd0);
    checkOutput("rst_fields", {pv28_o, pv56_o, pv88_o, pv120_o, pv126_o, pv132_o}, 133'd0);

    $display("[TB] clean frame");
    applyStimulus(32'h0ABCDEF1, 1'b1);
    applyStimulus(32'h01234567, 1'b0);
    applyStimulus(32'hFFFFFFFF, 1'b0);
    applyStimulus(32'h80000001, 1'b0);
    checkOutput("t1_no_valid_before_b4", {132'd0, frm_valid}, 133'd0);
    applyStimulus(32'h00000FC3, 1'b0);
    checkOutput("t1_valid_latency", {132'd0, frm_valid}, 133'd1);
    checkOutput("t1_pv28", {105'd0, pv28_o}, {105'd0, 28'hABCDEF1});
    checkOutput("t1_pv132_pv126", {121'd0, pv132_o, pv126_o}, {121'd0, 6'h3F, 6'h03});
    stepCycle();
    checkOutput("t1_cnt", {129'd0, frm_cnt}, 133'd1);
    checkOutput("t1_ready_back", {frm_valid, in_ready}, 133'b01);

    $display("[TB] consumer backpressure");
    frm_ready = 1'b0;
    sendFrame(32'h01111111, 32'h02222222, 32'h33333333, 32'h44444444, 32'h00000555);
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      checkOutput("t2_hold_handshake", {frm_valid, in_ready}, 133'b10);
      checkOutput("t2_hold_fields", {pv28_o, pv120_o}, {73'd0, 28'h1111111, 32'h44444444});
    end
    frm_ready = 1'b1;
    stepCycle();
    checkOutput("t2_cnt_after", {129'd0, frm_cnt}, 133'd2);
    stepCycle();
    checkOutput("t2_single_handoff", {frm_valid, frm_cnt}, {128'd0, 1'b0, 4'd2});
    checkOutput("t2_fields_kept", {101'd0, pv120_o}, {101'd0, 32'h44444444});

    $display("[TB] sof mid-frame");
    errBefore = errSeen;
    applyStimulus(32'h0AAAAAAA, 1'b1);
    applyStimulus(32'h0BBBBBBB, 1'b0);
    applyStimulus(32'h0CCCCCCC, 1'b1);
    checkOutput("t3_err_pulse", {132'd0, err_sync}, 133'd1);
    applyStimulus(32'h0DDDDDDD, 1'b0);
    checkOutput("t3_err_one_cycle", {132'd0, err_sync}, 133'd0);
    applyStimulus(32'h12345678, 1'b0);
    applyStimulus(32'h9ABCDEF0, 1'b0);
    applyStimulus(32'h00000ABC, 1'b0);
    checkOutput("t3_restart_pv28", {104'd0, frm_valid, pv28_o}, {104'd0, 1'b1, 28'hCCCCCCC});
    stepCycle();
    checkOutput("t3_err_count", 133'(errSeen - errBefore), 133'd1);

    $display("[TB] beat without sof in idle");
    applyStimulus(32'h12345678, 1'b0);
    checkOutput("t4_err_ready", {frm_valid, in_ready, err_sync}, 133'b011);
    stepCycle();
    checkOutput("t4_quiet", {frm_valid, err_sync}, 133'd0);

    $display("[TB] padding error");
    sendFrame(32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004, 32'h00001000);
    checkOutput("t5_pad_set", {frm_valid, frm_pad_err}, 133'b11);
    stepCycle();
    checkOutput("t5_pad_dropped", {132'd0, frm_pad_err}, 133'd0);
    sendFrame(32'h00000005, 32'h00000006, 32'h00000007, 32'h00000008, 32'h00000009);
    checkOutput("t5_pad_clean", {frm_valid, frm_pad_err}, 133'b10);
    stepCycle();

    $display("[TB] reset mid-frame");
    applyStimulus(32'h01010101, 1'b1);
    applyStimulus(32'h02020202, 1'b0);
    applyStimulus(32'h03030303, 1'b0);
    applyStimulus(32'h04040404, 1'b0);
    doReset();
    errBefore = errSeen;
    checkOutput("t6_after_rst", {in_ready, frm_valid, err_sync, frm_cnt, pv28_o},
                {100'd0, 1'b1, 1'b0, 1'b0, 4'd0, 28'd0});
    applyStimulus(32'h0FEDCBA9, 1'b1);
    applyStimulus(32'h08765432, 1'b0);
    applyStimulus(32'h11111111, 1'b0);
    applyStimulus(32'h22222222, 1'b0);
    checkOutput("t6_no_valid_before_b4", {132'd0, frm_valid}, 133'd0);
    applyStimulus(32'h00000333, 1'b0);
    checkOutput("t6_valid", {132'd0, frm_valid}, 133'd1);
    stepCycle();
    checkOutput("t6_cnt", {129'd0, frm_cnt}, 133'd1);
    checkOutput("t6_no_err", 133'(errSeen - errBefore), 133'd0);

    $display("[TB] counter wrap with random frames");
    doReset();
    for (int f = 0; f < (1 << CNT_W) + 1; f++) begin
      sendFrame($urandom, $urandom, $urandom, $urandom, $urandom & 32'h0000FFFF);
    end
    stepCycle();
    stepCycle();
    checkOutput("wrap_cnt", {129'd0, frm_cnt}, 133'd1);
    checkOutput("wrap_cnt_model", {129'd0, frm_cnt}, {129'd0, expCnt});

    stepCycle();
    checkOutput("queue_empty", 133'(expQ.size()), 133'd0);
    checkOutput("err_total", 133'(errSeen), 133'(expErr));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
